// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC parallel-bus write sequencer.
// Contents: bus widths, default phase timings, and the write FSM state type.
// Related build macro: RTC_BUS_WAIT_EN (used by rtc_bus_writer, not referenced here).
package rtc_bus_pkg;

    localparam int unsigned RTC_ADDR_W = 8;
    localparam int unsigned RTC_DATA_W = 8;

    // Default phase lengths in clk cycles.
    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_STROBE_DEF = 4;
    localparam int unsigned T_HOLD_DEF   = 2;
    localparam int unsigned T_GAP_DEF    = 3;

    typedef enum logic [3:0] {
        StIdle,
        StAddrSetup,
        StAddrStrobe,
        StAddrHold,
        StGap,
        StDataSetup,
        StDataStrobe,
        StDataHold,
        StDone
    } wr_state_e;

endpackage

// File: rtl/rtc_bus_writer_phase_timer.sv
// Loadable down-counter that times each bus phase.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val this edge (takes priority over counting)
//   load_val  - initial count, i.e. phase length minus one
//   expired   - count has reached zero
module rtc_bus_writer_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_writer.sv
// Write-side sequencer for the multiplexed address/data RTC bus.
// One accepted (addr, data) request produces an address bus cycle, a gap with
// cs_n high, then a data bus cycle, each with setup/strobe/hold timing.
// All outputs are decoded from registered state and captured registers only.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   bus_wait_n    - (only with RTC_BUS_WAIT_EN) low stretches the write strobe
//   start         - request, sampled only while idle
//   addr, data    - request payload, captured on accept
//   ad_out, ad_oe - AD bus value and its tri-state enable
//   ad_sel        - 0 address cycle, 1 data cycle
//   cs_n, wr_n    - chip select and write strobe, active low
//   rd_n          - read strobe, always inactive here
//   busy, done    - busy from accept through completion; done is a 1-cycle pulse
// Build macro: RTC_BUS_WAIT_EN adds the bus_wait_n strobe-extension input.
module rtc_bus_writer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_STROBE = T_STROBE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef RTC_BUS_WAIT_EN
    input  logic                  bus_wait_n,
`endif
    input  logic                  start,
    input  logic [RTC_ADDR_W-1:0] addr,
    input  logic [RTC_DATA_W-1:0] data,
    output logic [7:0]            ad_out,
    output logic                  ad_oe,
    output logic                  ad_sel,
    output logic                  cs_n,
    output logic                  wr_n,
    output logic                  rd_n,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_W-1:0] LdSetup  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LdStrobe = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LdHold   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LdGap    = CNT_W'(T_GAP - 1);

    wr_state_e             state_q, state_d;
    logic [RTC_ADDR_W-1:0] addr_q;
    logic [RTC_DATA_W-1:0] data_q;
    logic                  accept;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic                  expired;
    logic                  strobe_go;

    assign accept = (state_q == StIdle) && start;

    // A strobe only ends once its count has run out and the RTC is not stalling.
`ifdef RTC_BUS_WAIT_EN
    assign strobe_go = expired && bus_wait_n;
`else
    assign strobe_go = expired;
`endif

    rtc_bus_writer_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    // Next state and timer reload; each timed state reloads the counter on exit.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StAddrSetup;
                    load     = 1'b1;
                    load_val = LdSetup;
                end
            end
            StAddrSetup: begin
                if (expired) begin
                    state_d  = StAddrStrobe;
                    load     = 1'b1;
                    load_val = LdStrobe;
                end
            end
            StAddrStrobe: begin
                if (strobe_go) begin
                    state_d  = StAddrHold;
                    load     = 1'b1;
                    load_val = LdHold;
                end
            end
            StAddrHold: begin
                if (expired) begin
                    state_d  = StGap;
                    load     = 1'b1;
                    load_val = LdGap;
                end
            end
            StGap: begin
                if (expired) begin
                    state_d  = StDataSetup;
                    load     = 1'b1;
                    load_val = LdSetup;
                end
            end
            StDataSetup: begin
                if (expired) begin
                    state_d  = StDataStrobe;
                    load     = 1'b1;
                    load_val = LdStrobe;
                end
            end
            StDataStrobe: begin
                if (strobe_go) begin
                    state_d  = StDataHold;
                    load     = 1'b1;
                    load_val = LdHold;
                end
            end
            StDataHold: begin
                if (expired) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        ad_out = '0;
        ad_oe  = 1'b0;
        ad_sel = 1'b0;
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        unique case (state_q)
            StAddrSetup, StAddrStrobe, StAddrHold: begin
                ad_out = addr_q;
                ad_oe  = 1'b1;
                cs_n   = 1'b0;
                wr_n   = (state_q != StAddrStrobe);
            end
            StDataSetup, StDataStrobe, StDataHold: begin
                ad_out = data_q;
                ad_oe  = 1'b1;
                ad_sel = 1'b1;
                cs_n   = 1'b0;
                wr_n   = (state_q != StDataStrobe);
            end
            default: begin
            end
        endcase
    end

endmodule
